// File: rtl/level_sequencer.sv
// level_sequencer: Gold Miner level FSM loading per-level target/time and judging win or loss.
// Define LEVEL_SKIP_EN to add i_skipLevel, which wins the current level like reaching the target.
module level_sequencer #(
    parameter int NUM_LEVELS  = 4,
    parameter int SCORE_W     = 12,
    parameter int TIME_W      = 8,
    parameter int BASE_TARGET = 100,
    parameter int TARGET_STEP = 50,
    parameter int BASE_TIME   = 60,
    parameter int TIME_STEP   = 5,
    parameter int MIN_TIME    = 20,
    parameter int END_HOLD    = 3,
    localparam int LVL_W      = $clog2(NUM_LEVELS)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_enable,
    input  logic               i_startGame,
    input  logic               i_oneSecTick,
    input  logic [SCORE_W-1:0] i_score,
`ifdef LEVEL_SKIP_EN
    input  logic               i_skipLevel,
`endif
    output logic [LVL_W-1:0]   o_levelIdx,
    output logic [SCORE_W-1:0] o_targetScore,
    output logic [TIME_W-1:0]  o_timeLeft,
    output logic               o_drLevel,
    output logic               o_stageEnded,
    output logic               o_lastLevelEnded,
    output logic               o_gameOver
);
    localparam int SWW = SCORE_W + LVL_W + 1;
    localparam int TWW = TIME_W + LVL_W + 1;
    localparam int HW  = $clog2(END_HOLD + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_WON, S_LOST, S_DONE} state_t;

    state_t             r_state;
    logic [LVL_W-1:0]   r_level;
    logic [SCORE_W-1:0] r_target;
    logic [TIME_W-1:0]  r_time;
    logic [HW-1:0]      r_hold;
    logic               r_dr, r_stage_ended, r_last, r_over;

    logic [SWW-1:0]     w_target_raw;
    logic [TWW-1:0]     w_dec, w_time_raw;
    logic [SCORE_W-1:0] w_target;
    logic [TIME_W-1:0]  w_time;
    logic               w_skip, w_win;

`ifdef LEVEL_SKIP_EN
    assign w_skip = i_skipLevel;
`else
    assign w_skip = 1'b0;
`endif

    // Wide intermediates so large level indices saturate instead of wrapping.
    assign w_target_raw = SWW'(r_level) * SWW'(TARGET_STEP) + SWW'(BASE_TARGET);
    assign w_target     = (w_target_raw[SWW-1:SCORE_W] != '0) ? '1 : w_target_raw[SCORE_W-1:0];
    assign w_dec        = TWW'(r_level) * TWW'(TIME_STEP);
    assign w_time_raw   = (w_dec + TWW'(MIN_TIME) >= TWW'(BASE_TIME)) ? TWW'(MIN_TIME)
                                                                       : TWW'(BASE_TIME) - w_dec;
    assign w_time       = (w_time_raw[TWW-1:TIME_W] != '0) ? '1 : w_time_raw[TIME_W-1:0];
    assign w_win        = (i_score >= r_target) || w_skip;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_level       <= '0;
            r_target      <= '0;
            r_time        <= '0;
            r_hold        <= '0;
            r_dr          <= 1'b0;
            r_stage_ended <= 1'b0;
            r_last        <= 1'b0;
            r_over        <= 1'b0;
        end else if (i_enable) begin
            r_stage_ended <= 1'b0;
            if (i_startGame) begin
                r_state <= S_LOAD;
                r_level <= '0;
                r_dr    <= 1'b0;
                r_last  <= 1'b0;
                r_over  <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_state  <= S_PLAY;
                        r_target <= w_target;
                        r_time   <= w_time;
                        r_dr     <= 1'b1;
                    end
                    S_PLAY: begin
                        if (w_win) begin
                            r_state       <= S_WON;
                            r_stage_ended <= 1'b1;
                            r_hold        <= '0;
                            r_dr          <= 1'b0;
                        end else if (i_oneSecTick) begin
                            if (r_time == '0) begin
                                r_state <= S_LOST;
                                r_over  <= 1'b1;
                                r_dr    <= 1'b0;
                            end else begin
                                r_time <= r_time - 1'b1;
                            end
                        end
                    end
                    S_WON: begin
                        // The tick that brings the hold count to END_HOLD leaves the end screen.
                        if (i_oneSecTick) begin
                            if (r_hold == HW'(END_HOLD - 1)) begin
                                if (r_level == LVL_W'(NUM_LEVELS - 1)) begin
                                    r_state <= S_DONE;
                                    r_last  <= 1'b1;
                                end else begin
                                    r_level <= r_level + 1'b1;
                                    r_state <= S_LOAD;
                                end
                            end else begin
                                r_hold <= r_hold + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_levelIdx       = r_level;
    assign o_targetScore    = r_target;
    assign o_timeLeft       = r_time;
    assign o_drLevel        = r_dr;
    assign o_stageEnded     = r_stage_ended;
    assign o_lastLevelEnded = r_last;
    assign o_gameOver       = r_over;
endmodule
